hdmi_tpg_mc: RTL

Multi-mode, parametrised HDMI test pattern generator. It sits between the video timing generator and the HDMI/TMDS encoder. It derives its own pixel and line position from the incoming sync/DE stream and produces one of four patterns: colour bars, checkerboard, scrolling gray ramp, or moving box. The output is pipelined, with delayed syncs kept aligned to the pixel data.

---
 rtl/hdmi_tpg_mc_pkg.sv | 34 +++
 rtl/hdmi_tpg_pos.sv | 116 +++++++++++
 rtl/hdmi_tpg_mc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_tpg_mc_pkg.sv
// hdmi_tpg_mc_pkg: shared definitions for the HDMI test pattern generator.
// Holds the pattern mode encodings, the colour-bar table and the field
// positions of the packed {R, B, G} pixel word.
package hdmi_tpg_mc_pkg;

    // Pattern select encodings as seen on the mode input.
    typedef enum logic [1:0] {
        TPG_BARS  = 2'd0,
        TPG_CHECK = 2'd1,
        TPG_RAMP  = 2'd2,
        TPG_BOX   = 2'd3
    } tpg_mode_e;

    // Bit positions of the full-scale flags inside a COLOR_TABLE entry.
    localparam int FLAG_R = 2;
    localparam int FLAG_G = 1;
    localparam int FLAG_B = 0;

    // Component slot (in units of CW bits) inside the packed rbg word.
    localparam int FIELD_R = 2;
    localparam int FIELD_B = 1;
    localparam int FIELD_G = 0;

    // Colour bars left to right: white, yellow, cyan, green, magenta, red,
    // blue, black. Each entry is {R, G, B} full-scale flags.
    localparam logic [2:0] COLOR_TABLE [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010,
        3'b101, 3'b100, 3'b001, 3'b000
    };

    // Moving box edge length in pixels/lines.
    localparam int BOX_SIZE = 64;

endpackage

// File: rtl/hdmi_tpg_pos.sv
// hdmi_tpg_pos: stage 1 of the pattern generator.
// Detects vs rising / de falling edges, tracks the pixel position (x, y) and
// frame counter, and latches mode/act_ppl/act_lpf at each frame start.
// When HDMI_TPG_BOX_EN is defined it also advances the moving-box position.
module hdmi_tpg_pos
    import hdmi_tpg_mc_pkg::*;
#(
    parameter int BOX_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_mode,
    input  logic [11:0] i_act_ppl,
    input  logic [11:0] i_act_lpf,
    input  logic        i_vs,
    input  logic        i_hs,
    input  logic        i_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [7:0]  o_frame_cnt,
    output logic [1:0]  o_mode,
    output logic [11:0] o_ppl,
    output logic [11:0] o_lpf,
    output logic [11:0] o_box_x,
    output logic        o_vs,
    output logic        o_hs,
    output logic        o_de
);

    logic        r_vs, r_hs, r_de;
    logic [11:0] r_x, r_y;
    logic [11:0] r_cnt_x, r_cnt_y;
    logic [7:0]  r_frame_cnt;
    logic [1:0]  r_mode;
    logic [11:0] r_ppl, r_lpf;

    logic        w_vs_rise, w_de_fall;
    logic [11:0] w_px, w_py;

    // The registered syncs double as the "previous value" for edge detection.
    assign w_vs_rise = i_vs & ~r_vs;
    assign w_de_fall = ~i_de & r_de;

    // Frame start wins: the pixel arriving with the vs edge sits at (0, 0).
    assign w_px = w_vs_rise ? 12'd0 : r_cnt_x;
    assign w_py = w_vs_rise ? 12'd0 : r_cnt_y;

    // Position counters, frame counter and per-frame latches.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs        <= 1'b0;
            r_hs        <= 1'b0;
            r_de        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt_x     <= '0;
            r_cnt_y     <= '0;
            r_frame_cnt <= '0;
            r_mode      <= TPG_BARS;
            r_ppl       <= '0;
            r_lpf       <= '0;
        end else begin
            r_vs <= i_vs;
            r_hs <= i_hs;
            r_de <= i_de;
            r_x  <= w_px;
            r_y  <= w_py;
            if (w_vs_rise) begin
                r_cnt_x     <= {11'd0, i_de};
                r_cnt_y     <= '0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_mode      <= i_mode;
                r_ppl       <= i_act_ppl;
                r_lpf       <= i_act_lpf;
            end else if (i_de) begin
                r_cnt_x <= r_cnt_x + 12'd1;
            end else if (w_de_fall) begin
                r_cnt_x <= '0;
                r_cnt_y <= r_cnt_y + 12'd1;
            end
        end
    end

`ifdef HDMI_TPG_BOX_EN
    logic [11:0] r_box_x;
    logic [12:0] w_box_next;

    assign w_box_next = {1'b0, r_box_x} + 13'(BOX_STEP);

    // Box steps right once per frame and wraps when it would reach the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_box_x <= '0;
        end else if (w_vs_rise) begin
            r_box_x <= (w_box_next >= {1'b0, i_act_ppl}) ? 12'd0 : w_box_next[11:0];
        end
    end

    assign o_box_x = r_box_x;
`else
    assign o_box_x = '0;
`endif

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_frame_cnt = r_frame_cnt;
    assign o_mode      = r_mode;
    assign o_ppl       = r_ppl;
    assign o_lpf       = r_lpf;
    assign o_vs        = r_vs;
    assign o_hs        = r_hs;
    assign o_de        = r_de;

endmodule

// File: rtl/hdmi_tpg_mc.sv
// hdmi_tpg_mc: multi-mode HDMI test pattern generator (bars, checker,
// scrolling ramp, moving box) with a 3-cycle sync-aligned pipeline.
// Optional feature macro: HDMI_TPG_BOX_EN enables the moving box on mode 3;
// without it mode 3 produces colour bars.
module hdmi_tpg_mc
    import hdmi_tpg_mc_pkg::*;
#(
    parameter int CW       = 8,
    parameter int BAR_NUM  = 8,
    parameter int CELL_SH  = 5,
    parameter int BOX_STEP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic [11:0]   act_ppl,
    input  logic [11:0]   act_lpf,
    input  logic          vs_in,
    input  logic          hs_in,
    input  logic          de_in,
    output logic          vs_out,
    output logic          hs_out,
    output logic          de_out,
    output logic [3*CW-1:0] rbg
);

    localparam int BAR_SH = $clog2(BAR_NUM);
    localparam int COL_SH = 3 - BAR_SH;
    localparam int SUM_W  = (CW > 12) ? CW + 1 : 13;
    localparam logic [CW-1:0] MID_GRAY = CW'(1) << (CW - 1);

    // Stage 1 outputs
    logic [11:0] w_x, w_y, w_ppl, w_lpf, w_box_x;
    logic [7:0]  w_frame_cnt;
    logic [1:0]  w_mode_raw;
    logic        w_vs1, w_hs1, w_de1;
    tpg_mode_e   w_mode;

    hdmi_tpg_pos #(
        .BOX_STEP (BOX_STEP)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mode      (mode),
        .i_act_ppl   (act_ppl),
        .i_act_lpf   (act_lpf),
        .i_vs        (vs_in),
        .i_hs        (hs_in),
        .i_de        (de_in),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_frame_cnt (w_frame_cnt),
        .o_mode      (w_mode_raw),
        .o_ppl       (w_ppl),
        .o_lpf       (w_lpf),
        .o_box_x     (w_box_x),
        .o_vs        (w_vs1),
        .o_hs        (w_hs1),
        .o_de        (w_de1)
    );

    assign w_mode = tpg_mode_e'(w_mode_raw);

    // ---------------- Stage 2: pattern compute ----------------
    logic [11:0]     w_bar_w;
    logic [2:0]      w_bar_idx, w_col_idx;
    logic [2:0]      w_flags;
    logic [3*CW-1:0] w_bars, w_checker, w_ramp, w_pix;
    logic [SUM_W-1:0] w_ramp_sum;

    assign w_bar_w = w_ppl >> BAR_SH;

    // Bar index = number of bar boundaries at or left of x; colour via table.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_bar_idx = '0;
        for (int k = 1; k < BAR_NUM; k++) begin
            if (16'(k) * {4'd0, w_bar_w} <= {4'd0, w_x}) begin
                w_bar_idx = w_bar_idx + 3'd1;
            end
        end
        w_col_idx = w_bar_idx << COL_SH;
        w_flags   = COLOR_TABLE[w_col_idx];
        w_bars    = '0;
        w_bars[FIELD_R*CW +: CW] = {CW{w_flags[FLAG_R]}};
        w_bars[FIELD_B*CW +: CW] = {CW{w_flags[FLAG_B]}};
        w_bars[FIELD_G*CW +: CW] = {CW{w_flags[FLAG_G]}};
    end

    assign w_checker  = {(3*CW){~(w_x[CELL_SH] ^ w_y[CELL_SH])}};
    assign w_ramp_sum = SUM_W'(w_x) + SUM_W'(w_frame_cnt);
    assign w_ramp     = {3{w_ramp_sum[CW-1:0]}};

`ifdef HDMI_TPG_BOX_EN
    logic [11:0]     w_box_y;
    logic            w_in_box;
    logic [3*CW-1:0] w_box;
    logic            w_unused;

    assign w_box_y  = 12'({1'b0, w_lpf[11:1]} - 12'd32);
    assign w_in_box = ({1'b0, w_x} >= {1'b0, w_box_x}) &&
                      ({1'b0, w_x} <  ({1'b0, w_box_x} + 13'(BOX_SIZE))) &&
                      ({1'b0, w_y} >= {1'b0, w_box_y}) &&
                      ({1'b0, w_y} <  ({1'b0, w_box_y} + 13'(BOX_SIZE)));
    assign w_box    = w_in_box ? {(3*CW){1'b1}} : {3{MID_GRAY}};
    assign w_unused = w_lpf[0];
`else
    logic w_unused;
    assign w_unused = ^{w_y, w_lpf, w_box_x, MID_GRAY};
`endif

    // Mode mux; anything unrecognised (mode 3 without the box) is bars.
    always_comb begin
        w_pix = w_bars;
        case (w_mode)
            TPG_CHECK: w_pix = w_checker;
            TPG_RAMP:  w_pix = w_ramp;
`ifdef HDMI_TPG_BOX_EN
            TPG_BOX:   w_pix = w_box;
`endif
            default:   w_pix = w_bars;
        endcase
    end

    logic [3*CW-1:0] r_pix2, r_rbg3;
    logic            r_vs2, r_hs2, r_de2;
    logic            r_vs3, r_hs3, r_de3;

    // Stage 2 register: pattern pixel plus syncs delayed alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix2 <= '0;
            r_vs2  <= 1'b0;
            r_hs2  <= 1'b0;
            r_de2  <= 1'b0;
        end else begin
            r_pix2 <= w_pix;
            r_vs2  <= w_vs1;
            r_hs2  <= w_hs1;
            r_de2  <= w_de1;
        end
    end

    // Stage 3 output register: blank pixel data outside the active area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rbg3 <= '0;
            r_vs3  <= 1'b0;
            r_hs3  <= 1'b0;
            r_de3  <= 1'b0;
        end else begin
            r_rbg3 <= r_de2 ? r_pix2 : '0;
            r_vs3  <= r_vs2;
            r_hs3  <= r_hs2;
            r_de3  <= r_de2;
        end
    end

    assign rbg    = r_rbg3;
    assign vs_out = r_vs3;
    assign hs_out = r_hs3;
    assign de_out = r_de3;

endmodule
